// File: rtl/instr_mem_ctrl_pkg.sv
// instr_mem_ctrl_pkg: shared FSM states and constants for the instruction memory controller
package instr_mem_ctrl_pkg;
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_e;
  localparam logic [31:0] NOP = 32'h0;
  localparam int DEPTH_DEF = 512;
endpackage

// File: rtl/instr_mem_ctrl_if.sv
// instr_mem_ctrl_if: fetch and program-load signals of the instruction memory controller
interface instr_mem_ctrl_if #(parameter int ADDR_W = 9);
  logic [31:0] if_addr;
  logic if_req;
  logic if_stall;
  logic [31:0] if_instr;
  logic if_valid;
  logic if_fault;
  logic ld_start;
  logic [31:0] ld_data;
  logic ld_valid;
  logic ld_ready;
  logic ld_done;
  logic ld_ovf;
  logic [ADDR_W:0] ld_count;
  logic busy;
  modport master (
    output if_addr, if_req, if_stall, ld_start, ld_data, ld_valid, ld_done,
    input if_instr, if_valid, if_fault, ld_ready, ld_ovf, ld_count, busy
  );
  modport slave (
    input if_addr, if_req, if_stall, ld_start, ld_data, ld_valid, ld_done,
    output if_instr, if_valid, if_fault, ld_ready, ld_ovf, ld_count, busy
  );
endinterface

// File: rtl/instr_mem_ctrl_ram.sv
// instr_ram: DEPTH x 32 storage, one write port and one synchronous read port
module instr_ram #(
  parameter int DEPTH = 512,
  parameter int ADDR_W = 9
) (
  input logic clk,
  input logic rst_n,
  input logic we,
  input logic [ADDR_W-1:0] waddr,
  input logic [31:0] wdata,
  input logic re,
  input logic [ADDR_W-1:0] raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // Only the read register is reset so if_instr starts at NOP; the array is cleared by sweep.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with clear sweep, program load and 1-cycle fetch port
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset,
  instr_mem_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d, idx, waddr;
  logic [ADDR_W:0] ld_ptr_q, ld_ptr_d;
  logic ld_ready_q, ld_ready_d, ld_ovf_q, ld_ovf_d, busy_q, busy_d;
  logic valid_q, valid_d, fault_q, fault_d;
  logic illegal, fetch, has_room, ld_wr, we;
  logic [31:0] wdata, rdata;
  assign idx = bus.if_addr[ADDR_W+1:2];
  assign illegal = (|bus.if_addr[1:0]) || (|bus.if_addr[31:ADDR_W+2]) || (32'(idx) >= DEPTH);
  assign has_room = ld_ptr_q < (ADDR_W+1)'(DEPTH);
  assign fetch = state_q == IDLE && bus.if_req && !bus.if_stall;
  assign ld_wr = state_q == LOAD && bus.ld_valid && has_room;
  assign we = state_q == CLEAR || ld_wr;
  assign waddr = state_q == CLEAR ? clr_ptr_q : ld_ptr_q[ADDR_W-1:0];
  assign wdata = state_q == CLEAR ? NOP : bus.ld_data;
  always_comb begin
    state_d = state_q;
    clr_ptr_d = clr_ptr_q;
    ld_ptr_d = ld_ptr_q + (ADDR_W+1)'(ld_wr);
    ld_ovf_d = ld_ovf_q | (state_q == LOAD && bus.ld_valid && !has_room);
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q == ADDR_W'(DEPTH-1) ? '0 : clr_ptr_q + 1'b1;
      state_d = clr_ptr_q == ADDR_W'(DEPTH-1) ? IDLE : CLEAR;
    end else if (state_q == IDLE && bus.ld_start) begin
      state_d = LOAD;
      ld_ptr_d = '0;
      ld_ovf_d = 1'b0;
    end else if (state_q == LOAD && bus.ld_done) begin
      state_d = IDLE;
    end
    ld_ready_d = state_d == LOAD && ld_ptr_d < (ADDR_W+1)'(DEPTH);
    busy_d = state_d != IDLE;
    valid_d = bus.if_stall ? valid_q : fetch;
    fault_d = fetch ? illegal : fault_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      ld_ptr_q <= '0;
      ld_ready_q <= 1'b0;
      ld_ovf_q <= 1'b0;
      busy_q <= 1'b1;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ptr_q <= ld_ptr_d;
      ld_ready_q <= ld_ready_d;
      ld_ovf_q <= ld_ovf_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  instr_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst_n(reset),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(fetch && !illegal),
    .raddr(idx),
    .rdata(rdata)
  );
  // A faulted response reads as NOP; the read register only moves on legal fetches.
  assign bus.if_instr = fault_q ? NOP : rdata;
  assign bus.if_valid = valid_q;
  assign bus.if_fault = fault_q;
  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_ovf = ld_ovf_q;
  assign bus.ld_count = ld_ptr_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed checks of clear, load, fetch, stall, fault and overflow behaviour
module tb_instr_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  instr_mem_ctrl_if #(.ADDR_W(9)) a ();
  instr_mem_ctrl_if #(.ADDR_W(2)) b ();
  instr_mem_ctrl #(.DEPTH(512), .ADDR_W(9)) dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  instr_mem_ctrl #(.DEPTH(4), .ADDR_W(2)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (a.busy && n < 2000) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    #2 reset = 1'b0;
    #1;
    checks++; if (a.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b exp=1", a.busy); end
    checks++; if (a.if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", a.if_valid); end
    checks++; if (a.if_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", a.if_instr); end
    checks++; if (a.if_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", a.if_fault); end
    checks++; if (a.ld_ready !== 1'b0 || a.ld_ovf !== 1'b0) begin failures++; $display("FAIL rst_ld got=%b%b exp=00", a.ld_ready, a.ld_ovf); end
    checks++; if (a.ld_count !== 10'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", a.ld_count); end
    cyc();
    reset = 1'b1;
    wait_clear(n);
    checks++; if (n != 512) begin failures++; $display("FAIL clear_cycles got=%0d exp=512", n); end
  endtask

  task automatic test_fetch_after_clear();
    a.if_addr = 32'h0; a.if_req = 1'b1;
    cyc();
    checks++; if (a.if_instr !== 32'h0 || a.if_valid !== 1'b1 || a.if_fault !== 1'b0) begin failures++; $display("FAIL clr_fetch got=%h/%b/%b exp=0/1/0", a.if_instr, a.if_valid, a.if_fault); end
  endtask

  task automatic test_load();
    logic [31:0] w [3] = '{32'h20040020, 32'h20050000, 32'h20060004};
    a.ld_start = 1'b1;
    cyc();
    a.ld_start = 1'b0;
    checks++; if (a.busy !== 1'b1 || a.ld_ready !== 1'b1 || a.if_valid !== 1'b1) begin failures++; $display("FAIL ld_enter busy/ready/valid got=%b%b%b exp=111", a.busy, a.ld_ready, a.if_valid); end
    for (int i = 0; i < 3; i++) begin
      a.ld_valid = 1'b1; a.ld_data = w[i];
      cyc();
      if (i == 0) begin
        checks++; if (a.if_valid !== 1'b0) begin failures++; $display("FAIL fetch_in_load valid got=%b exp=0", a.if_valid); end
      end
    end
    a.ld_valid = 1'b0; a.if_req = 1'b0; a.ld_done = 1'b1;
    cyc();
    a.ld_done = 1'b0;
    checks++; if (a.busy !== 1'b0 || a.ld_ready !== 1'b0) begin failures++; $display("FAIL ld_exit busy/ready got=%b%b exp=00", a.busy, a.ld_ready); end
    checks++; if (a.ld_count !== 10'd3 || a.ld_ovf !== 1'b0) begin failures++; $display("FAIL ld_count got=%0d ovf=%b exp=3 ovf=0", a.ld_count, a.ld_ovf); end
    a.if_addr = 32'h8; a.if_req = 1'b1;
    cyc();
    checks++; if (a.if_instr !== 32'h20060004 || a.if_valid !== 1'b1) begin failures++; $display("FAIL fetch8 got=%h/%b exp=20060004/1", a.if_instr, a.if_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3] = '{32'h20040020, 32'h20050000, 32'h20060004};
    for (int i = 0; i < 3; i++) begin
      a.if_addr = 32'(i * 4); a.if_req = 1'b1;
      cyc();
      checks++; if (a.if_instr !== w[i] || a.if_valid !== 1'b1) begin failures++; $display("FAIL b2b[%0d] got=%h/%b exp=%h/1", i, a.if_instr, a.if_valid, w[i]); end
    end
    a.if_req = 1'b0;
    cyc();
    checks++; if (a.if_valid !== 1'b0 || a.if_instr !== 32'h20060004) begin failures++; $display("FAIL idle_hold got=%h/%b exp=20060004/0", a.if_instr, a.if_valid); end
  endtask

  task automatic test_stall();
    a.if_addr = 32'h4; a.if_req = 1'b1;
    cyc();
    checks++; if (a.if_instr !== 32'h20050000) begin failures++; $display("FAIL stall_pre got=%h exp=20050000", a.if_instr); end
    a.if_stall = 1'b1; a.if_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (a.if_instr !== 32'h20050000 || a.if_valid !== 1'b1) begin failures++; $display("FAIL stall[%0d] got=%h/%b exp=20050000/1", i, a.if_instr, a.if_valid); end
    end
    a.if_stall = 1'b0;
    cyc();
    checks++; if (a.if_instr !== 32'h20040020) begin failures++; $display("FAIL stall_release got=%h exp=20040020", a.if_instr); end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2] = '{32'h800, 32'h6};
    for (int i = 0; i < 2; i++) begin
      a.if_addr = bad[i]; a.if_req = 1'b1;
      cyc();
      checks++; if (a.if_instr !== 32'h0 || a.if_fault !== 1'b1 || a.if_valid !== 1'b1) begin failures++; $display("FAIL illegal_%h got=%h/f%b/v%b exp=0/f1/v1", bad[i], a.if_instr, a.if_fault, a.if_valid); end
    end
    a.if_addr = 32'h4;
    cyc();
    checks++; if (a.if_instr !== 32'h20050000 || a.if_fault !== 1'b0) begin failures++; $display("FAIL after_fault got=%h/f%b exp=20050000/f0", a.if_instr, a.if_fault); end
    a.if_req = 1'b0;
  endtask

  task automatic test_reload_done_same_cycle();
    a.ld_start = 1'b1;
    cyc();
    a.ld_start = 1'b0;
    checks++; if (a.ld_count !== 10'd0) begin failures++; $display("FAIL reload_count0 got=%0d exp=0", a.ld_count); end
    a.ld_valid = 1'b1; a.ld_data = 32'hDEADBEEF; a.ld_done = 1'b1;
    cyc();
    a.ld_valid = 1'b0; a.ld_done = 1'b0;
    checks++; if (a.busy !== 1'b0 || a.ld_count !== 10'd1) begin failures++; $display("FAIL reload_exit busy=%b count=%0d exp busy=0 count=1", a.busy, a.ld_count); end
    a.if_addr = 32'h0; a.if_req = 1'b1;
    cyc();
    checks++; if (a.if_instr !== 32'hDEADBEEF) begin failures++; $display("FAIL wbr_fetch0 got=%h exp=deadbeef", a.if_instr); end
    a.if_addr = 32'h4;
    cyc();
    checks++; if (a.if_instr !== 32'h20050000) begin failures++; $display("FAIL keep_fetch4 got=%h exp=20050000", a.if_instr); end
    a.if_req = 1'b0;
  endtask

  task automatic test_overflow();
    b.ld_start = 1'b1;
    cyc();
    b.ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.ld_valid = 1'b1; b.ld_data = 32'hB0000000 + 32'(i);
      cyc();
      if (i == 2) begin
        checks++; if (b.ld_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready3 got=%b exp=1", b.ld_ready); end
      end
    end
    b.ld_valid = 1'b0;
    checks++; if (b.ld_ready !== 1'b0 || b.ld_count !== 3'd4 || b.ld_ovf !== 1'b0) begin failures++; $display("FAIL ovf_full ready=%b count=%0d ovf=%b exp 0/4/0", b.ld_ready, b.ld_count, b.ld_ovf); end
    b.ld_valid = 1'b1; b.ld_data = 32'hBBBBBBBB;
    cyc();
    b.ld_valid = 1'b0; b.ld_done = 1'b1;
    checks++; if (b.ld_ovf !== 1'b1 || b.ld_count !== 3'd4) begin failures++; $display("FAIL ovf_set ovf=%b count=%0d exp 1/4", b.ld_ovf, b.ld_count); end
    cyc();
    b.ld_done = 1'b0; b.if_addr = 32'h0; b.if_req = 1'b1;
    cyc();
    checks++; if (b.if_instr !== 32'hB0000000 || b.ld_ovf !== 1'b1) begin failures++; $display("FAIL ovf_word0 got=%h ovf=%b exp=b0000000 ovf=1", b.if_instr, b.ld_ovf); end
    b.if_addr = 32'hC;
    cyc();
    checks++; if (b.if_instr !== 32'hB0000003) begin failures++; $display("FAIL ovf_word3 got=%h exp=b0000003", b.if_instr); end
    b.if_addr = 32'h10;
    cyc();
    checks++; if (b.if_fault !== 1'b1 || b.if_instr !== 32'h0) begin failures++; $display("FAIL ovf_oob got=%h/f%b exp=0/f1", b.if_instr, b.if_fault); end
    b.if_req = 1'b0; b.ld_start = 1'b1;
    cyc();
    b.ld_start = 1'b0; b.ld_done = 1'b1;
    checks++; if (b.ld_ovf !== 1'b0 || b.ld_count !== 3'd0) begin failures++; $display("FAIL ovf_clear ovf=%b count=%0d exp 0/0", b.ld_ovf, b.ld_count); end
    cyc();
    b.ld_done = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int n;
    a.ld_start = 1'b1;
    cyc();
    a.ld_start = 1'b0; a.ld_valid = 1'b1; a.ld_data = 32'h11111111;
    cyc();
    a.ld_data = 32'h22222222;
    cyc();
    #2 reset = 1'b0;
    #1;
    checks++; if (a.busy !== 1'b1 || a.ld_count !== 10'd0 || a.ld_ready !== 1'b0) begin failures++; $display("FAIL midrst busy=%b count=%0d ready=%b exp 1/0/0", a.busy, a.ld_count, a.ld_ready); end
    a.ld_valid = 1'b0;
    cyc();
    reset = 1'b1;
    wait_clear(n);
    checks++; if (n != 512) begin failures++; $display("FAIL midrst_clear got=%0d exp=512", n); end
    a.if_addr = 32'h0; a.if_req = 1'b1;
    cyc();
    checks++; if (a.if_instr !== 32'h0 || a.if_valid !== 1'b1) begin failures++; $display("FAIL midrst_fetch0 got=%h/%b exp=0/1", a.if_instr, a.if_valid); end
    a.if_addr = 32'h4;
    cyc();
    checks++; if (a.if_instr !== 32'h0) begin failures++; $display("FAIL midrst_fetch4 got=%h exp=0", a.if_instr); end
    a.if_req = 1'b0;
  endtask

  initial begin
    a.if_addr = '0; a.if_req = 0; a.if_stall = 0; a.ld_start = 0; a.ld_data = '0; a.ld_valid = 0; a.ld_done = 0;
    b.if_addr = '0; b.if_req = 0; b.if_stall = 0; b.ld_start = 0; b.ld_data = '0; b.ld_valid = 0; b.ld_done = 0;
    test_reset();
    test_fetch_after_clear();
    test_load();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reload_done_same_cycle();
    test_overflow();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 512, meaning number of 32-bit instruction words held.
REQ-002 Parameter ADDR_W, default 9, meaning word-index width; SHALL equal clog2(DEPTH).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous and active-low.
REQ-005 Port if_addr  input  32  byte address of fetch; word index = if_addr[ADDR_W+1:2].
REQ-006 Port if_req  input  1  fetch request.
REQ-007 Port if_stall  input  1  pipeline stall; holds fetch response.
REQ-008 Port if_instr  output  32  fetched instruction.
REQ-009 Port if_valid  output  1  if_instr carries a valid response.
REQ-010 Port if_fault  output  1  response came from an illegal address.
REQ-011 Port ld_start  input  1  begin program load.
REQ-012 Port ld_data  input  32  instruction word to load.
REQ-013 Port ld_valid  input  1  ld_data valid.
REQ-014 Port ld_ready  output  1  controller accepts ld_data.
REQ-015 Port ld_done  input  1  end program load.
REQ-016 Port ld_ovf  output  1  sticky: load exceeded DEPTH words.
REQ-017 Port ld_count  output  ADDR_W+1  words written in current/last load.
REQ-018 Port busy  output  1  high in CLEAR and LOAD states.

Function
REQ-019 FSM states CLEAR, IDLE, LOAD; reset deassertion starts in CLEAR.
REQ-020 CLEAR: writes 0 to word clr_ptr, clr_ptr 0..DEPTH-1, one word per cycle; after word DEPTH-1 -> IDLE (exactly DEPTH cycles).
REQ-021 IDLE, if_req=1, if_stall=0: next cycle if_instr=mem[index], if_valid=1, if_fault=0 (1-cycle latency, back-to-back every cycle).
REQ-022 IDLE, if_req=0, if_stall=0: next cycle if_valid=0, if_instr unchanged.
REQ-023 if_stall=1: if_instr, if_valid, if_fault hold previous values regardless of if_req.
REQ-024 Illegal fetch (if_addr[1:0]!=0 or if_addr[31:ADDR_W+2]!=0 or index>=DEPTH): if_instr=0 (NOP), if_valid=1, if_fault=1.
REQ-025 Fetch requests in CLEAR or LOAD: if_valid=0 next cycle (unless stalled); no memory read.
REQ-026 IDLE, ld_start=1 -> LOAD; ld_ptr=0, ld_count=0, ld_ovf=0; ld_start in CLEAR/LOAD ignored.
REQ-027 LOAD: ld_ready=1 while ld_ptr<DEPTH; ld_valid&ld_ready writes mem[ld_ptr], ld_ptr and ld_count +1.
REQ-028 ld_ptr==DEPTH: ld_ready=0, further ld_valid ignored, ld_ovf set on first ignored ld_valid and held until next ld_start or reset.
REQ-029 ld_done in LOAD -> IDLE next cycle; ld_valid&ld_ready in same cycle writes the word first.
REQ-030 Words not written during a load keep prior contents.
REQ-031 Fetch in first IDLE cycle after a load returns newly written data (write-before-read).

Reset
REQ-032 reset low asynchronously: state=CLEAR, clr_ptr=0, ld_ptr=0, if_instr=0, if_valid=0, if_fault=0, ld_ready=0, ld_ovf=0, ld_count=0, busy=1.
REQ-033 Memory array not reset directly; cleared by CLEAR sweep; reset mid-LOAD aborts load and re-clears.

Structure
REQ-034 Shared package holds FSM state enum, NOP constant 32'h0, default DEPTH.
REQ-035 Storage SHALL be one sub-module instr_ram (1 write port, 1 synchronous read port, DEPTH x 32).

Verification
REQ-036 Reset release, DEPTH=512 -> busy=1 for 512 cycles then 0; fetch 0x00000000 -> if_instr=0, if_valid=1.
REQ-037 Load 0x20040020, 0x20050000, 0x20060004, ld_done -> ld_count=3; fetch 0x8 -> 0x20060004 one cycle later.
REQ-038 Fetch 0x4, stall 3 cycles with if_addr changed to 0x0 -> if_instr holds 0x20050000 until stall drops.
REQ-039 Fetch 0x800 and 0x6 -> if_instr=0, if_fault=1 each.
REQ-040 DEPTH=4, load 5 words -> ld_ready=0 after 4th, ld_ovf=1, ld_count=4, word 5 not written.
REQ-041 reset low after 2 load words -> busy=1, CLEAR sweep, subsequent fetch 0x0 returns 0.
